uart_hex_loader: RTL

//  Parametrised ASCII-hex program loader between a byte-level UART core and an instruction memory.
//  - Accepts received bytes and echoes each one back.
//  - Packs hex digits MSB-first into WORD_W-bit words and writes them to sequential addresses.
//  - Handles command characters: address rewind, run, stop.
//  - Replaces the fixed 16x32 nibble-accumulator loader; adds bounds protection, lowercase hex,

---
 rtl/uart_loader_pkg.sv | 17 +
 rtl/hex_char_decode.sv | 24 ++
 rtl/uart_hex_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and character codes for the ASCII-hex program loader.
package uart_loader_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DECODE = 2'd1,
      S_WRITE  = 2'd2,
      S_GAP    = 2'd3
   } state_e;

   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_AT = 8'h40;
   localparam logic [7:0] CH_G  = 8'h47;
   localparam logic [7:0] CH_S  = 8'h53;

endpackage

// File: rtl/hex_char_decode.sv
// ASCII to nibble decoder: accepts 0-9, A-F and a-f.
module hex_char_decode
   import uart_loader_pkg::*;
(
   input  logic [7:0] char_i,
   output logic [3:0] nibble_c_o,
   output logic       is_hex_c_o
);

   always_comb begin
      nibble_c_o = 4'h0;
      is_hex_c_o = 1'b0;
      if (char_i >= 8'h30 && char_i <= 8'h39) begin
         nibble_c_o = char_i[3:0];
         is_hex_c_o = 1'b1;
      end else if ((char_i >= 8'h41 && char_i <= 8'h46) ||
                   (char_i >= 8'h61 && char_i <= 8'h66)) begin
         // Letters A-F / a-f share low nibble 1..6, so value is low nibble + 9.
         nibble_c_o = char_i[3:0] + 4'd9;
         is_hex_c_o = 1'b1;
      end
   end

endmodule

// File: rtl/uart_hex_loader.sv
// UART ASCII-hex loader: echoes bytes, packs hex into words, writes sequential memory.
// Optional write checksum accumulator enabled by macro LOADER_CKSUM_EN.
module uart_hex_loader
   import uart_loader_pkg::*;
#(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned ADDR_W = $clog2(DEPTH),
   parameter int unsigned ECHO   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ack,
   input  logic              tx_busy,
   output logic              tx_wr,
   output logic [7:0]        tx_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              full,
   output logic              overflow,
   output logic              err,
   output logic              run,
   output logic [WORD_W-1:0] cksum
);

   localparam int unsigned NIBS  = WORD_W / 4;
   localparam int unsigned NIB_W = $clog2(NIBS + 1);
   localparam int unsigned CNT_W = ADDR_W + 1;

   state_e            state_q;
   logic [7:0]        byte_q;
   logic [NIB_W-1:0]  nib_q;
   logic [WORD_W-1:0] shift_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  count_q;
   logic              full_q, ovf_q, err_q, run_q;
   logic              rx_ack_q, tx_wr_q, mem_we_q;
   logic [7:0]        tx_data_q;

   logic [3:0]        nibble_c;
   logic              is_hex_c;
   logic [WORD_W-1:0] shift_d;
   logic [NIB_W-1:0]  nib_d;
   logic              word_done_c;

   hex_char_decode u_dec (
      .char_i     (byte_q),
      .nibble_c_o (nibble_c),
      .is_hex_c_o (is_hex_c)
   );

   assign shift_d     = WORD_W'({shift_q, nibble_c});
   assign nib_d       = nib_q + NIB_W'(1);
   assign word_done_c = (nib_d == NIB_W'(NIBS));

   // Byte handshake, decode and memory write sequencing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         byte_q    <= '0;
         nib_q     <= '0;
         shift_q   <= '0;
         addr_q    <= '0;
         count_q   <= '0;
         full_q    <= 1'b0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
         run_q     <= 1'b0;
         rx_ack_q  <= 1'b0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= '0;
         mem_we_q  <= 1'b0;
      end else begin
         rx_ack_q <= 1'b0;
         tx_wr_q  <= 1'b0;
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rx_valid && !tx_busy) begin
                  byte_q    <= rx_data;
                  tx_data_q <= rx_data;
                  rx_ack_q  <= 1'b1;
                  tx_wr_q   <= (ECHO != 0);
                  state_q   <= S_DECODE;
               end
            end
            S_DECODE: begin
               state_q <= S_GAP;
               if (is_hex_c) begin
                  if (!run_q) begin
                     shift_q <= shift_d;
                     if (word_done_c) begin
                        nib_q <= '0;
                        if (!full_q) begin
                           state_q  <= S_WRITE;
                           mem_we_q <= 1'b1;
                        end else begin
                           ovf_q <= 1'b1;
                        end
                     end else begin
                        nib_q <= nib_d;
                     end
                  end
               end else begin
                  case (byte_q)
                     CH_LF, CH_CR: begin
                        if (nib_q != '0) err_q <= 1'b1;
                        nib_q <= '0;
                     end
                     CH_AT: begin
                        addr_q  <= '0;
                        count_q <= '0;
                        nib_q   <= '0;
                        full_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        err_q   <= 1'b0;
                     end
                     CH_G: begin
                        run_q <= 1'b1;
                        if (nib_q != '0) err_q <= 1'b1;
                        nib_q <= '0;
                     end
                     CH_S:    run_q <= 1'b0;
                     default: ;
                  endcase
               end
            end
            S_WRITE: begin
               state_q <= S_GAP;
               count_q <= count_q + CNT_W'(1);
               // Address parks on the last word once memory fills.
               if (count_q + CNT_W'(1) == CNT_W'(DEPTH)) full_q <= 1'b1;
               else                                      addr_q <= addr_q + ADDR_W'(1);
            end
            S_GAP:   state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef LOADER_CKSUM_EN
   logic [WORD_W-1:0] cksum_q;

   // XOR of every word written since reset or the last rewind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         cksum_q <= '0;
      else if (state_q == S_DECODE && byte_q == CH_AT)    cksum_q <= '0;
      else if (state_q == S_WRITE)                        cksum_q <= cksum_q ^ shift_q;
   end

   assign cksum = cksum_q;
`else
   assign cksum = '0;
`endif

   assign rx_ack     = rx_ack_q;
   assign tx_wr      = tx_wr_q;
   assign tx_data    = tx_data_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = shift_q;
   assign word_count = count_q;
   assign full       = full_q;
   assign overflow   = ovf_q;
   assign err        = err_q;
   assign run        = run_q;

endmodule
